pid_controller_v2: RTL and testbench
====================================

# pid_controller_v2

Parametrised, fully pipelined PID controller with valid handshake, fixed-point coefficient scaling, a saturating integrator with anti-windup, and a saturated output. It sits between the ADC sample path and the DAC/actuator path. It accepts one sample per cycle. It is the successor to the single-width, unsaturated `pid_controller`.

## Interface
- `DATA_WIDTH`, 14: width of `data_in` and `set_point`, two's complement.
- `COEF_WIDTH`, 16: width of `p_coef`, `i_coef` and `d_coef`, two's complement.
- `FRAC_BITS`, 12: number of fractional bits in the coefficients. A coefficient of 2^FRAC_BITS means a gain of 1.0.
- `ACC_WIDTH`, 32: integrator width. Must be ≥ COEF_WIDTH+DATA_WIDTH+2; elaboration fails otherwise.
- `OUT_WIDTH`, 14: width of `data_out`, two's complement.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: qualifies `data_in` and `set_point`.
- `data_in`, in, DATA_WIDTH: measured value.
- `set_point`, in, DATA_WIDTH: target value.
- `p_coef`, `i_coef`, `d_coef`, in, COEF_WIDTH each: gains. Sampled together with the data at stage 2.
- `int_clear`, in, 1: synchronous integrator clear.
- `out_valid`, out, 1: qualifies `data_out`.
- `data_out`, out, OUT_WIDTH: control output.
- `sat_hi`, `sat_lo`, out, 1 each: `data_out` is clamped at its maximum / minimum.
- `int_sat`, out, 1: the integrator is clamped at its ACC_WIDTH limit.

## Operation
**Stage 1** (on `in_valid`):
- e = set_point − data_in, held in DATA_WIDTH+1 bits, so it cannot overflow.
- d = e − e_prev, held in DATA_WIDTH+2 bits.
- e_prev is then updated to e.
- e_prev updates only on `in_valid`. It is 0 after reset, so the first sample's d equals e.

**Stage 2**: pp = p_coef·e, ip = i_coef·e, dp = d_coef·d. These are full-precision signed products.

**Stage 3**: integrator update. The rules are applied in this priority order:
1. `int_clear` high: acc ← 0. This takes precedence over a valid sample in the same cycle.
2. Anti-windup freeze: acc holds if the previous valid output had `sat_hi` and ip > 0, or had `sat_lo` and ip < 0.
3. Otherwise: acc ← sat_ACC(acc + ip). `int_sat` is set when this sum is clamped to ±(2^(ACC_WIDTH−1)), with the negative limit at −2^(ACC_WIDTH−1) and the positive limit at 2^(ACC_WIDTH−1)−1. `int_sat` clears on the next unclamped update or on clear.

In the same stage, sum = pp + acc_new + dp, computed in ACC_WIDTH+2 bits.

**Stage 4**:
- y = sum >>> FRAC_BITS. This is an arithmetic shift, so it truncates toward −∞.
- data_out = clamp(y, −2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1).
- `sat_hi` / `sat_lo` are set when clamping occurs.

**General behaviour**:
- Bubbles: when `in_valid` is 0, no state advances. This covers e_prev, acc and the saturation history. `out_valid` is 0 in the corresponding cycle.
- When `out_valid` is low, `data_out` and the flags hold their last values.
- There is no backpressure. The consumer must accept every `out_valid` beat.

## Timing
- Latency is exactly 4 cycles: `in_valid` sampled at edge n gives `out_valid` = 1 after edge n+4.
- Throughput is 1 sample per cycle, and back-to-back samples are supported.
- `int_clear` asserted at edge n affects every output whose stage 3 occurs at edge n. It also applies with no valid sample in flight.
- Anti-windup uses the registered flags from the most recent stage-4 valid output. In back-to-back operation this feedback is one sample stale, by design.
- Reset: all pipeline registers, e_prev and acc go to 0. `out_valid`, `data_out`, `sat_hi`, `sat_lo` and `int_sat` are 0 from `rst_n` low. Asserting reset mid-stream drops all in-flight samples; no `out_valid` appears for them after release.
- The first sample accepted after reset release gives `out_valid` 4 cycles later.

## Test plan
All scenarios use the default parameters.
1. **Proportional only.** p=4096, i=d=0, set_point=4096, data_in=2048, `in_valid` held high → `data_out`=2048 from the 4th cycle on. No flags set.
2. **Integral with anti-windup.** i=4096, p=d=0, e=2048, continuous valid → `data_out` = 2048, 4096, 6144, 8191 with `sat_hi` on the 4th output. acc then stays at 4·2048·4096 while `sat_hi` persists; check that the stale-flag step is at most one extra accumulation. `int_clear` pulse → the next output is 0 or 2048 per the clear-precedence rule.
3. **Derivative step.** d=4096, p=i=0, constant e=2048 → first output 2048, then 0. Step data_in to 1024 → one output of 1024, then 0.
4. **Negative saturation and floor.** p=4096, e=−8192 (set_point=−8192, data_in=0), then e=−1 with p=1 → `data_out`=−8192 with `sat_lo`, then −1 (floor, not 0).
5. **Bubbles and latency.** Valid pattern 1,0,1,1,0 → `out_valid` reproduces the same pattern delayed exactly 4 cycles. e_prev and acc are unchanged across the gaps.
6. **Reset mid-stream.** Pull `rst_n` low with 3 samples in flight → all outputs 0 immediately and no stray `out_valid` after release. The next sample's derivative is computed against e_prev=0.

Source files
------------

// File: rtl/pid_controller_v2.sv
// -----------------------------------------------------------------------------
// pid_controller_v2
//
// Fully pipelined fixed-point PID controller, one sample per cycle, four
// cycles of latency from an accepted sample to its out_valid beat.
//
//   edge n   : input register (set_point, data_in, in_valid)
//   edge n+1 : error e and first difference d = e - e_prev
//   edge n+2 : full-precision products p*e, i*e, d*d (coefficients sampled here)
//   edge n+3 : integrator update (clear / anti-windup / saturate) and PID sum
//   edge n+4 : arithmetic shift by FRAC_BITS, clamp to OUT_WIDTH, flags
//
// Ports
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   in_valid   : qualifies data_in / set_point
//   data_in    : measured value, signed DATA_WIDTH
//   set_point  : target value, signed DATA_WIDTH
//   p_coef     : proportional gain, signed COEF_WIDTH, FRAC_BITS fractional bits
//   i_coef     : integral gain, same format
//   d_coef     : derivative gain, same format
//   int_clear  : synchronous integrator clear (wins over a sample in stage 3)
//   out_valid  : qualifies data_out
//   data_out   : control output, signed OUT_WIDTH, held between valid beats
//   sat_hi     : data_out sits on its positive rail
//   sat_lo     : data_out sits on its negative rail
//   int_sat    : integrator clamped at its ACC_WIDTH limit
// -----------------------------------------------------------------------------
module pid_controller_v2 #(
    parameter int DATA_WIDTH = 14,
    parameter int COEF_WIDTH = 16,
    parameter int FRAC_BITS  = 12,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] data_in,
    input  logic signed [DATA_WIDTH-1:0] set_point,
    input  logic signed [COEF_WIDTH-1:0] p_coef,
    input  logic signed [COEF_WIDTH-1:0] i_coef,
    input  logic signed [COEF_WIDTH-1:0] d_coef,
    input  logic                         int_clear,
    output logic                         out_valid,
    output logic signed [OUT_WIDTH-1:0]  data_out,
    output logic                         sat_hi,
    output logic                         sat_lo,
    output logic                         int_sat
);

    // Internal widths: error, difference, products, integrator+1, sum.
    localparam int EW  = DATA_WIDTH + 1;
    localparam int DW  = DATA_WIDTH + 2;
    localparam int PW  = COEF_WIDTH + EW;
    localparam int DPW = COEF_WIDTH + DW;
    localparam int AXW = ACC_WIDTH + 1;
    localparam int SW  = ACC_WIDTH + 2;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [SW-1:0]        Y_MAX   = {{(SW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]        Y_MIN   = {{(SW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    // The integrator must be able to absorb one full i*e product plus headroom.
    generate
        if (ACC_WIDTH < COEF_WIDTH + DATA_WIDTH + 2) begin : g_acc_width_check
            $error("pid_controller_v2: ACC_WIDTH must be >= COEF_WIDTH+DATA_WIDTH+2");
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Input register
    // -------------------------------------------------------------------------
    logic                  in_valid_q;
    logic [DATA_WIDTH-1:0] data_in_q;
    logic [DATA_WIDTH-1:0] set_point_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_valid_q  <= 1'b0;
            data_in_q   <= '0;
            set_point_q <= '0;
        end else begin
            in_valid_q <= in_valid;
            if (in_valid) begin
                data_in_q   <= data_in;
                set_point_q <= set_point;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1: error and first difference
    // -------------------------------------------------------------------------
    // e_q only loads on a valid sample, so between samples it already holds
    // the previous sample's error and doubles as e_prev.
    logic                 s1_valid_q;
    logic signed [EW-1:0] sp_x;
    logic signed [EW-1:0] din_x;
    logic signed [EW-1:0] e_d;
    logic signed [EW-1:0] e_q;
    logic signed [DW-1:0] e_dx;
    logic signed [DW-1:0] e_prev_dx;
    logic signed [DW-1:0] d_d;
    logic signed [DW-1:0] d_q;

    assign sp_x      = {set_point_q[DATA_WIDTH-1], set_point_q};
    assign din_x     = {data_in_q[DATA_WIDTH-1], data_in_q};
    assign e_d       = sp_x - din_x;
    assign e_dx      = {e_d[EW-1], e_d};
    assign e_prev_dx = {e_q[EW-1], e_q};
    assign d_d       = e_dx - e_prev_dx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            e_q        <= '0;
            d_q        <= '0;
        end else begin
            s1_valid_q <= in_valid_q;
            if (in_valid_q) begin
                e_q <= e_d;
                d_q <= d_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: full-precision products
    // -------------------------------------------------------------------------
    logic                  s2_valid_q;
    logic signed [PW-1:0]  p_x;
    logic signed [PW-1:0]  i_x;
    logic signed [PW-1:0]  e_px;
    logic signed [DPW-1:0] dc_x;
    logic signed [DPW-1:0] d_px;
    logic signed [PW-1:0]  pp_d;
    logic signed [PW-1:0]  ip_d;
    logic signed [DPW-1:0] dp_d;
    logic signed [PW-1:0]  pp_q;
    logic signed [PW-1:0]  ip_q;
    logic signed [DPW-1:0] dp_q;

    // Operands are sign-extended to the product width so each product is exact.
    assign p_x  = {{(PW-COEF_WIDTH){p_coef[COEF_WIDTH-1]}}, p_coef};
    assign i_x  = {{(PW-COEF_WIDTH){i_coef[COEF_WIDTH-1]}}, i_coef};
    assign e_px = {{(PW-EW){e_q[EW-1]}}, e_q};
    assign dc_x = {{(DPW-COEF_WIDTH){d_coef[COEF_WIDTH-1]}}, d_coef};
    assign d_px = {{(DPW-DW){d_q[DW-1]}}, d_q};
    assign pp_d = p_x * e_px;
    assign ip_d = i_x * e_px;
    assign dp_d = dc_x * d_px;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            pp_q       <= '0;
            ip_q       <= '0;
            dp_q       <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                pp_q <= pp_d;
                ip_q <= ip_d;
                dp_q <= dp_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: integrator and PID sum
    // -------------------------------------------------------------------------
    logic                        s3_valid_q;
    logic signed [ACC_WIDTH-1:0] acc_q;
    logic signed [ACC_WIDTH-1:0] acc_d;
    logic                        int_sat_q;
    logic                        int_sat_d;
    logic signed [AXW-1:0]       acc_x;
    logic signed [AXW-1:0]       ip_ax;
    logic signed [AXW-1:0]       acc_sum;
    logic                        acc_ovf;
    logic signed [ACC_WIDTH-1:0] acc_clamped;
    logic                        ip_pos;
    logic                        ip_neg;
    logic                        freeze;
    logic signed [SW-1:0]        pp_sx;
    logic signed [SW-1:0]        acc_sx;
    logic signed [SW-1:0]        dp_sx;
    logic signed [SW-1:0]        sum_d;
    logic signed [SW-1:0]        sum_q;
    logic                        sat_hi_q;
    logic                        sat_lo_q;

    assign acc_x   = {acc_q[ACC_WIDTH-1], acc_q};
    assign ip_ax   = {{(AXW-PW){ip_q[PW-1]}}, ip_q};
    assign acc_sum = acc_x + ip_ax;
    // One guard bit: overflow shows up as a disagreement of the top two bits,
    // and the guard bit tells which rail to clamp to.
    assign acc_ovf     = acc_sum[AXW-1] ^ acc_sum[AXW-2];
    assign acc_clamped = !acc_ovf ? acc_sum[ACC_WIDTH-1:0]
                                  : (acc_sum[AXW-1] ? ACC_MIN : ACC_MAX);

    assign ip_neg = ip_q[PW-1];
    assign ip_pos = !ip_q[PW-1] && (|ip_q);
    // Anti-windup looks at the flags of the last valid output; in back-to-back
    // streaming these lag by one sample, so one extra step can slip through.
    assign freeze = (sat_hi_q && ip_pos) || (sat_lo_q && ip_neg);

    always_comb begin
        acc_d     = acc_q;
        int_sat_d = int_sat_q;
        if (int_clear) begin
            acc_d     = '0;
            int_sat_d = 1'b0;
        end else if (s2_valid_q && !freeze) begin
            acc_d     = acc_clamped;
            int_sat_d = acc_ovf;
        end
    end

    // The sum uses the freshly updated integrator value.
    assign pp_sx  = {{(SW-PW){pp_q[PW-1]}}, pp_q};
    assign acc_sx = {{(SW-ACC_WIDTH){acc_d[ACC_WIDTH-1]}}, acc_d};
    assign dp_sx  = {{(SW-DPW){dp_q[DPW-1]}}, dp_q};
    assign sum_d  = pp_sx + acc_sx + dp_sx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q <= 1'b0;
            acc_q      <= '0;
            int_sat_q  <= 1'b0;
            sum_q      <= '0;
        end else begin
            s3_valid_q <= s2_valid_q;
            acc_q      <= acc_d;
            int_sat_q  <= int_sat_d;
            if (s2_valid_q) begin
                sum_q <= sum_d;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 4: scale, clamp, flags
    // -------------------------------------------------------------------------
    logic signed [SW-1:0]        y_full;
    logic signed [OUT_WIDTH-1:0] data_out_d;
    logic signed [OUT_WIDTH-1:0] data_out_q;
    logic                        sat_hi_d;
    logic                        sat_lo_d;
    logic                        out_valid_q;

    // Arithmetic shift: truncation toward minus infinity.
    assign y_full = sum_q >>> FRAC_BITS;

    // A flag is raised whenever the output lands on a rail, including reaching
    // it exactly, so anti-windup engages as soon as the output is pinned.
    always_comb begin
        data_out_d = y_full[OUT_WIDTH-1:0];
        sat_hi_d   = 1'b0;
        sat_lo_d   = 1'b0;
        if (y_full >= Y_MAX) begin
            data_out_d = Y_MAX[OUT_WIDTH-1:0];
            sat_hi_d   = 1'b1;
        end else if (y_full <= Y_MIN) begin
            data_out_d = Y_MIN[OUT_WIDTH-1:0];
            sat_lo_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sat_hi_q    <= 1'b0;
            sat_lo_q    <= 1'b0;
        end else begin
            out_valid_q <= s3_valid_q;
            if (s3_valid_q) begin
                data_out_q <= data_out_d;
                sat_hi_q   <= sat_hi_d;
                sat_lo_q   <= sat_lo_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign sat_hi    = sat_hi_q;
    assign sat_lo    = sat_lo_q;
    assign int_sat   = int_sat_q;

endmodule

// File: tb/tb_pid_controller_v2.sv
// -----------------------------------------------------------------------------
// tb_pid_controller_v2
//
// Directed testbench for pid_controller_v2 with default parameters. A monitor
// records every out_valid beat with its cycle number; each scenario task drives
// its samples, flushes the pipeline and compares the recorded beats against
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_pid_controller_v2;

    localparam int DW = 14;
    localparam int CW = 16;
    localparam int OW = 14;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  in_valid  = 1'b0;
    logic                  int_clear = 1'b0;
    logic signed [DW-1:0]  data_in   = '0;
    logic signed [DW-1:0]  set_point = '0;
    logic signed [CW-1:0]  p_coef    = '0;
    logic signed [CW-1:0]  i_coef    = '0;
    logic signed [CW-1:0]  d_coef    = '0;
    logic                  out_valid;
    logic signed [OW-1:0]  data_out;
    logic                  sat_hi;
    logic                  sat_lo;
    logic                  int_sat;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        int   cyc;
        int   data;
        logic hi;
        logic lo;
        logic isat;
    } beat_t;

    beat_t beats[$];
    int    in_cycles[$];

    always #5 clk = ~clk;

    pid_controller_v2 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .set_point (set_point),
        .p_coef    (p_coef),
        .i_coef    (i_coef),
        .d_coef    (d_coef),
        .int_clear (int_clear),
        .out_valid (out_valid),
        .data_out  (data_out),
        .sat_hi    (sat_hi),
        .sat_lo    (sat_lo),
        .int_sat   (int_sat)
    );

    // Monitor: sample just after each rising edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (out_valid === 1'b1) begin
            beats.push_back('{cyc, int'(data_out), sat_hi, sat_lo, int_sat});
            $display("beat cyc=%0d data_out=%0d sat_hi=%0b sat_lo=%0b int_sat=%0b",
                     cyc, data_out, sat_hi, sat_lo, int_sat);
        end
    end

    // One input cycle, applied on the falling edge.
    task automatic drive(input logic v, input int sp, input int din, input logic clr);
        @(negedge clk);
        in_valid  = v;
        set_point = sp[DW-1:0];
        data_in   = din[DW-1:0];
        int_clear = clr;
        if (v) in_cycles.push_back(cyc + 1);
    endtask

    // Bubbles carry junk data that must never be absorbed.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 777, -333, 1'b0);
    endtask

    task automatic clear_pulse();
        drive(1'b0, 777, -333, 1'b1);
        idle(2);
        beats.delete();
        in_cycles.delete();
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if (data_out !== '0) $display("FAIL reset_data_out: got %0d want 0", data_out); else n_pass++;
        n_checks++; if (sat_hi !== 1'b0) $display("FAIL reset_sat_hi: got %0b want 0", sat_hi); else n_pass++;
        n_checks++; if (sat_lo !== 1'b0) $display("FAIL reset_sat_lo: got %0b want 0", sat_lo); else n_pass++;
        n_checks++; if (int_sat !== 1'b0) $display("FAIL reset_int_sat: got %0b want 0", int_sat); else n_pass++;
        rst_n = 1'b1;
        beats.delete();
        in_cycles.delete();
    endtask

    // -------------------------------------------------------------------------
    // d = 1.0, e: 2048,2048,2048,3072,3072,3072 with e_prev = 0 after reset.
    task automatic test_derivative();
        int exp_d [6] = '{2048, 0, 0, 1024, 0, 0};
        p_coef = 16'sd0; i_coef = 16'sd0; d_coef = 16'sd4096;
        for (int k = 0; k < 3; k++) drive(1'b1, 4096, 2048, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, 4096, 1024, 1'b0);
        idle(8);
        n_checks++; if (beats.size() !== 6) $display("FAIL deriv_count: got %0d want 6", beats.size()); else n_pass++;
        for (int k = 0; k < 6 && k < beats.size(); k++) begin
            n_checks++;
            if (beats[k].data !== exp_d[k]) $display("FAIL deriv_data[%0d]: got %0d want %0d", k, beats[k].data, exp_d[k]);
            else n_pass++;
            n_checks++;
            if ({beats[k].hi, beats[k].lo} !== 2'b00) $display("FAIL deriv_flags[%0d]: got %b want 00", k, {beats[k].hi, beats[k].lo});
            else n_pass++;
        end
        beats.delete();
        in_cycles.delete();
    endtask

    // -------------------------------------------------------------------------
    // p = 1.0, e = 2048 held: 2048 on every beat, exactly 4 cycles after input.
    task automatic test_proportional();
        p_coef = 16'sd4096; i_coef = 16'sd0; d_coef = 16'sd0;
        for (int k = 0; k < 6; k++) drive(1'b1, 4096, 2048, 1'b0);
        idle(8);
        n_checks++; if (beats.size() !== 6) $display("FAIL prop_count: got %0d want 6", beats.size()); else n_pass++;
        for (int k = 0; k < 6 && k < beats.size() && k < in_cycles.size(); k++) begin
            n_checks++;
            if (beats[k].data !== 2048) $display("FAIL prop_data[%0d]: got %0d want 2048", k, beats[k].data);
            else n_pass++;
            n_checks++;
            if ({beats[k].hi, beats[k].lo, beats[k].isat} !== 3'b000)
                $display("FAIL prop_flags[%0d]: got %b want 000", k, {beats[k].hi, beats[k].lo, beats[k].isat});
            else n_pass++;
            n_checks++;
            if (beats[k].cyc - in_cycles[k] !== 4)
                $display("FAIL prop_latency[%0d]: got %0d want 4", k, beats[k].cyc - in_cycles[k]);
            else n_pass++;
        end
        beats.delete();
        in_cycles.delete();
    endtask

    // -------------------------------------------------------------------------
    // i = 1.0: eight samples of e=+2048 then four of e=-2048. The 5th sample
    // still accumulates (stale flag), later positive samples are frozen at
    // 5*2048*4096; the negative ones then unwind 4x, 3x, 2x, 1x.
    task automatic test_integral();
        int   exp_d  [12] = '{2048, 4096, 6144, 8191, 8191, 8191, 8191, 8191, 8191, 6144, 4096, 2048};
        logic exp_hi [12] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        p_coef = 16'sd0; i_coef = 16'sd4096; d_coef = 16'sd0;
        clear_pulse();
        for (int k = 0; k < 8; k++) drive(1'b1, 2048, 0, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b1, 0, 2048, 1'b0);
        idle(8);
        n_checks++; if (beats.size() !== 12) $display("FAIL integ_count: got %0d want 12", beats.size()); else n_pass++;
        for (int k = 0; k < 12 && k < beats.size(); k++) begin
            n_checks++;
            if (beats[k].data !== exp_d[k]) $display("FAIL integ_data[%0d]: got %0d want %0d", k, beats[k].data, exp_d[k]);
            else n_pass++;
            n_checks++;
            if ({beats[k].hi, beats[k].lo, beats[k].isat} !== {exp_hi[k], 2'b00})
                $display("FAIL integ_flags[%0d]: got %b want %b", k, {beats[k].hi, beats[k].lo, beats[k].isat}, {exp_hi[k], 2'b00});
            else n_pass++;
        end
        beats.delete();
        in_cycles.delete();
    endtask

    // -------------------------------------------------------------------------
    // Integrator holds 2048*4096 from the previous test. A lone clear empties
    // it (next = 2048, not 4096); a clear coinciding with a sample's stage 3
    // wins (output 0); the sample after that starts from zero again (2048).
    task automatic test_int_clear();
        int exp_d [3] = '{2048, 0, 2048};
        idle(2);
        drive(1'b0, 777, -333, 1'b1);
        idle(2);
        drive(1'b1, 2048, 0, 1'b0);
        idle(6);
        drive(1'b1, 2048, 0, 1'b0);
        idle(2);
        drive(1'b0, 777, -333, 1'b1);
        idle(4);
        drive(1'b1, 2048, 0, 1'b0);
        idle(6);
        n_checks++; if (beats.size() !== 3) $display("FAIL clear_count: got %0d want 3", beats.size()); else n_pass++;
        for (int k = 0; k < 3 && k < beats.size(); k++) begin
            n_checks++;
            if (beats[k].data !== exp_d[k]) $display("FAIL clear_data[%0d]: got %0d want %0d", k, beats[k].data, exp_d[k]);
            else n_pass++;
        end
        beats.delete();
        in_cycles.delete();
    endtask

    // -------------------------------------------------------------------------
    // Output clamping at both rails, then p = 1 LSB showing floor behaviour.
    task automatic test_saturation();
        int   sp_v  [8] = '{-8192, -8192, 8191,  8191, 100, -1, 1, -1};
        int   din_v [8] = '{0,     8191,  -8192, 0,    0,   0,  0, 0};
        int   exp_d [8] = '{-8192, -8192, 8191,  8191, 100, -1, 0, -1};
        logic [1:0] exp_f [8] = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        p_coef = 16'sd4096; i_coef = 16'sd0; d_coef = 16'sd0;
        clear_pulse();
        for (int k = 0; k < 5; k++) drive(1'b1, sp_v[k], din_v[k], 1'b0);
        idle(6);
        p_coef = 16'sd1;
        for (int k = 5; k < 8; k++) drive(1'b1, sp_v[k], din_v[k], 1'b0);
        idle(6);
        n_checks++; if (beats.size() !== 8) $display("FAIL sat_count: got %0d want 8", beats.size()); else n_pass++;
        for (int k = 0; k < 8 && k < beats.size(); k++) begin
            n_checks++;
            if (beats[k].data !== exp_d[k]) $display("FAIL sat_data[%0d]: got %0d want %0d", k, beats[k].data, exp_d[k]);
            else n_pass++;
            n_checks++;
            if ({beats[k].hi, beats[k].lo} !== exp_f[k])
                $display("FAIL sat_flags[%0d]: got %b want %b", k, {beats[k].hi, beats[k].lo}, exp_f[k]);
            else n_pass++;
        end
        beats.delete();
        in_cycles.delete();
    endtask

    // -------------------------------------------------------------------------
    // Valid pattern 1,0,1,1,0 with i = d = 1.0, e = 1024, e_prev = -1 going in.
    // A: d=1025, acc=1024 -> 2049; B: d=0, acc=2048 -> 2048; C: 3072.
    task automatic test_bubbles();
        int exp_d [3] = '{2049, 2048, 3072};
        p_coef = 16'sd0; i_coef = 16'sd4096; d_coef = 16'sd4096;
        clear_pulse();
        drive(1'b1, 1024, 0, 1'b0);
        drive(1'b0, 777, -333, 1'b0);
        drive(1'b1, 1024, 0, 1'b0);
        drive(1'b1, 1024, 0, 1'b0);
        drive(1'b0, 777, -333, 1'b0);
        idle(7);
        n_checks++; if (beats.size() !== 3) $display("FAIL bubble_count: got %0d want 3", beats.size()); else n_pass++;
        for (int k = 0; k < 3 && k < beats.size() && k < in_cycles.size(); k++) begin
            n_checks++;
            if (beats[k].data !== exp_d[k]) $display("FAIL bubble_data[%0d]: got %0d want %0d", k, beats[k].data, exp_d[k]);
            else n_pass++;
            n_checks++;
            if (beats[k].cyc - in_cycles[k] !== 4)
                $display("FAIL bubble_latency[%0d]: got %0d want 4", k, beats[k].cyc - in_cycles[k]);
            else n_pass++;
        end
        n_checks++; if (data_out !== 14'sd3072) $display("FAIL bubble_hold: got %0d want 3072", data_out); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL bubble_idle_valid: got %0b want 0", out_valid); else n_pass++;
        beats.delete();
        in_cycles.delete();
    endtask

    // -------------------------------------------------------------------------
    // Three samples in flight when reset hits: nothing comes out, and the next
    // sample's derivative is taken against e_prev = 0 (d = 1.0, e = 1000).
    task automatic test_reset_mid_stream();
        int exp_d [2] = '{1000, 0};
        p_coef = 16'sd0; i_coef = 16'sd0; d_coef = 16'sd4096;
        clear_pulse();
        for (int k = 0; k < 3; k++) drive(1'b1, 1000, 0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        n_checks++; if (data_out !== '0) $display("FAIL midrst_data_out: got %0d want 0", data_out); else n_pass++;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %0b want 0", out_valid); else n_pass++;
        n_checks++; if ({sat_hi, sat_lo, int_sat} !== 3'b000)
            $display("FAIL midrst_flags: got %b want 000", {sat_hi, sat_lo, int_sat}); else n_pass++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        n_checks++; if (beats.size() !== 0) $display("FAIL midrst_stray: got %0d beats want 0", beats.size()); else n_pass++;
        beats.delete();
        in_cycles.delete();
        for (int k = 0; k < 2; k++) drive(1'b1, 1000, 0, 1'b0);
        idle(7);
        n_checks++; if (beats.size() !== 2) $display("FAIL midrst_count: got %0d want 2", beats.size()); else n_pass++;
        for (int k = 0; k < 2 && k < beats.size(); k++) begin
            n_checks++;
            if (beats[k].data !== exp_d[k]) $display("FAIL midrst_data[%0d]: got %0d want %0d", k, beats[k].data, exp_d[k]);
            else n_pass++;
        end
        beats.delete();
        in_cycles.delete();
    endtask

    initial begin
        test_reset();
        test_derivative();
        test_proportional();
        test_integral();
        test_int_clear();
        test_saturation();
        test_bubbles();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
